// File: rtl/burst_write_pkg.sv
// Shared types and helpers for the burst write master.
// Optional statistics counters in the top are enabled with BURST_WRITE_MASTER_STATS_EN.
package burst_write_pkg;

  // Master FSM encoding: IDLE=0, WAIT_DATA=1, BURST=2, DONE=3
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_BURST     = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  // Largest legal burst for a given burstcount width
  function automatic int unsigned max_burst(input int unsigned burst_width);
    return 32'(1) << (burst_width - 1);
  endfunction

  // Unsigned minimum
  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/burst_write_fifo.sv
// Show-ahead synchronous FIFO: q presents the head word whenever the FIFO is
// non-empty, and reads as zero when empty. Pushes while full are dropped.
module burst_write_fifo #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH_LOG2 = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      data,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      q,
  output logic [FIFO_DEPTH_LOG2:0]   count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned DEPTH = 32'(1) << FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W = FIFO_DEPTH_LOG2 + 1;

  logic [DATA_WIDTH-1:0]      r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CNT_W-1:0]           r_count;
  logic                       w_push;
  logic                       w_pop;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign q      = empty ? '0 : r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/burst_write_master_fifo.sv
// Avalon-MM burst write master fed by a show-ahead FIFO. A burst starts only
// once the FIFO already holds every beat, so master_write never drops mid-burst.
// Define BURST_WRITE_MASTER_STATS_EN to add stall-cycle and burst counters.
module burst_write_master_fifo
  import burst_write_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned BYTE_ENABLE_WIDTH = 4,
  parameter int unsigned BURST_WIDTH       = 4,
  parameter int unsigned LENGTH_WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH_LOG2   = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ctrl_start,
  input  logic [ADDRESS_WIDTH-1:0]      ctrl_baseaddress,
  input  logic [LENGTH_WIDTH-1:0]       ctrl_length,
  output logic                          ctrl_busy,
  output logic                          ctrl_done,
  input  logic                          user_write,
  input  logic [DATA_WIDTH-1:0]         user_writedata,
  output logic                          user_full,
  output logic [ADDRESS_WIDTH-1:0]      master_address,
  output logic                          master_write,
  output logic [DATA_WIDTH-1:0]         master_writedata,
  output logic [BURST_WIDTH-1:0]        master_burstcount,
  output logic [BYTE_ENABLE_WIDTH-1:0]  master_byteenable,
  input  logic                          master_waitrequest
`ifdef BURST_WRITE_MASTER_STATS_EN
  ,
  output logic [31:0]                   stat_wait_cycles,
  output logic [15:0]                   stat_bursts
`endif
);

  localparam int unsigned MAX_BURST = max_burst(BURST_WIDTH);
  localparam int unsigned CNT_W     = FIFO_DEPTH_LOG2 + 1;

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [LENGTH_WIDTH-1:0]  r_remaining;
  logic [BURST_WIDTH-1:0]   r_beats_left;

  logic [DATA_WIDTH-1:0]    w_fifo_q;
  logic [CNT_W-1:0]         w_fifo_count;
  logic                     w_fifo_empty;
  logic [BURST_WIDTH-1:0]   w_beats;
  logic                     w_fifo_ready;
  logic                     w_accept;
  logic                     w_last_beat;
  logic [ADDRESS_WIDTH-1:0] w_step_bytes;
  logic [LENGTH_WIDTH-1:0]  w_rem_after;

  burst_write_fifo #(
    .DATA_WIDTH      (DATA_WIDTH),
    .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (user_write),
    .data  (user_writedata),
    .pop   (w_accept),
    .q     (w_fifo_q),
    .count (w_fifo_count),
    .full  (user_full),
    .empty (w_fifo_empty)
  );

  assign master_writedata  = w_fifo_q;
  assign master_byteenable = '1;

  assign w_beats      = BURST_WIDTH'(min_u(MAX_BURST, 32'(r_remaining)));
  assign w_fifo_ready = (32'(w_fifo_count) >= 32'(w_beats));
  assign w_accept     = master_write & ~master_waitrequest & ~w_fifo_empty;
  assign w_last_beat  = w_accept & (r_beats_left == BURST_WIDTH'(1));
  assign w_step_bytes = ADDRESS_WIDTH'(master_burstcount) * ADDRESS_WIDTH'(BYTE_ENABLE_WIDTH);
  assign w_rem_after  = r_remaining - LENGTH_WIDTH'(master_burstcount);

  // Transfer sequencing: wait for a full burst of data, stream it, repeat
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= ST_IDLE;
      r_addr            <= '0;
      r_remaining       <= '0;
      r_beats_left      <= '0;
      master_address    <= '0;
      master_write      <= 1'b0;
      master_burstcount <= '0;
      ctrl_busy         <= 1'b0;
      ctrl_done         <= 1'b0;
    end else begin
      ctrl_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ctrl_start) begin
            r_addr      <= ctrl_baseaddress;
            r_remaining <= ctrl_length;
            ctrl_busy   <= 1'b1;
            r_state     <= (ctrl_length != '0) ? ST_WAIT_DATA : ST_DONE;
          end
        end
        ST_WAIT_DATA: begin
          if (w_fifo_ready) begin
            master_write      <= 1'b1;
            master_burstcount <= w_beats;
            master_address    <= r_addr;
            r_beats_left      <= w_beats;
            r_state           <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_accept) begin
            r_beats_left <= r_beats_left - BURST_WIDTH'(1);
          end
          if (w_last_beat) begin
            master_write <= 1'b0;
            r_addr       <= r_addr + w_step_bytes;
            r_remaining  <= w_rem_after;
            r_state      <= (w_rem_after == '0) ? ST_DONE : ST_WAIT_DATA;
          end
        end
        ST_DONE: begin
          ctrl_done <= 1'b1;
          ctrl_busy <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef BURST_WRITE_MASTER_STATS_EN
  // Saturating stall and completed-burst counters, cleared per transfer
  always_ff @(posedge clk) begin
    if (reset || (r_state == ST_IDLE && ctrl_start)) begin
      stat_wait_cycles <= '0;
      stat_bursts      <= '0;
    end else begin
      if (master_write && master_waitrequest && (stat_wait_cycles != '1)) begin
        stat_wait_cycles <= stat_wait_cycles + 32'd1;
      end
      if (r_state == ST_BURST && w_last_beat && (stat_bursts != '1)) begin
        stat_bursts <= stat_bursts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_burst_write_master_fifo.sv
// Self-checking bench for burst_write_master_fifo. A queue models the FIFO and
// the expected burst sequence is derived from base address and length alone.
module tb_burst_write_master_fifo;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctrl_start;
  logic [31:0] ctrl_baseaddress;
  logic [15:0] ctrl_length;
  logic        ctrl_busy;
  logic        ctrl_done;
  logic        user_write;
  logic [31:0] user_writedata;
  logic        user_full;
  logic [31:0] master_address;
  logic        master_write;
  logic [31:0] master_writedata;
  logic [3:0]  master_burstcount;
  logic [3:0]  master_byteenable;
  logic        master_waitrequest;

  burst_write_master_fifo dut (
    .clk                (clk),
    .reset              (reset),
    .ctrl_start         (ctrl_start),
    .ctrl_baseaddress   (ctrl_baseaddress),
    .ctrl_length        (ctrl_length),
    .ctrl_busy          (ctrl_busy),
    .ctrl_done          (ctrl_done),
    .user_write         (user_write),
    .user_writedata     (user_writedata),
    .user_full          (user_full),
    .master_address     (master_address),
    .master_write       (master_write),
    .master_writedata   (master_writedata),
    .master_burstcount  (master_burstcount),
    .master_byteenable  (master_byteenable),
    .master_waitrequest (master_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] exp_addr;
  int exp_rem, xfer_len, cur_beats, beat_idx, beats_total;
  int done_cnt, done_cyc, start_cyc, busy_cycles, cyc;
  int push_mode, wait_mode;
  bit in_burst, stalled;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int min8(input int r);
    return (r < 8) ? r : 8;
  endfunction

  // Start-to-done sample distance when data is always ready and no stalls
  function automatic int exp_latency(input int len);
    int r, lat, b;
    r = len;
    lat = 2;
    while (r > 0) begin
      b = min8(r);
      lat += 1 + b;
      r -= b;
    end
    return lat;
  endfunction

  // One clock: drive per-cycle stimulus, check outputs, advance the model
  task automatic step();
    logic wr;
    logic [31:0] exp_d;
    bit full_now;
    bit do_push;
    wr = 1'b0;
    if (wait_mode == 1) begin
      if (master_write && in_burst && !stalled && (beat_idx == 1 || beat_idx == 4)) begin
        wr = 1'b1;
        stalled = 1'b1;
      end
    end else if (wait_mode == 2) begin
      wr = ($urandom_range(0, 2) == 0);
    end
    master_waitrequest = wr;
    if (push_mode == 1) begin
      user_write = ($urandom_range(0, 1) == 1);
      user_writedata = $urandom;
    end else if (push_mode == 2) begin
      user_write = (cyc % 3 == 0);
      user_writedata = $urandom;
    end
    full_now = (mq.size() == DEPTH);
    chk("user_full", 64'(user_full), 64'(full_now));
    if (ctrl_busy) busy_cycles++;
    if (ctrl_done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", 64'(ctrl_busy), 64'(0));
    end
    if (in_burst) chk("write_held", 64'(master_write), 64'(1));
    if (master_write) begin
      if (!in_burst) begin
        in_burst = 1'b1;
        beat_idx = 0;
        cur_beats = min8(exp_rem);
        chk("fifo_ready", 64'(mq.size() >= cur_beats), 64'(1));
      end
      exp_d = (mq.size() > 0) ? mq[0] : 32'hDEADBEEF;
      chk("address", 64'(master_address), 64'(exp_addr));
      chk("burstcount", 64'(master_burstcount), 64'(cur_beats));
      chk("writedata", 64'(master_writedata), 64'(exp_d));
      chk("busy_in_burst", 64'(ctrl_busy), 64'(1));
      if (!wr && !reset && mq.size() > 0) begin
        void'(mq.pop_front());
        stalled = 1'b0;
        beat_idx++;
        beats_total++;
        if (beat_idx == cur_beats) begin
          in_burst = 1'b0;
          beat_idx = 0;
          exp_addr = exp_addr + 32'(cur_beats * 4);
          exp_rem -= cur_beats;
        end
      end
    end
    do_push = user_write && !full_now && !reset;
    if (do_push) mq.push_back(user_writedata);
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      mq.delete();
      in_burst = 1'b0;
      stalled = 1'b0;
      beat_idx = 0;
    end
  endtask

  task automatic push_seq(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      user_write = 1'b1;
      user_writedata = rnd ? $urandom : 32'(i + 1);
      step();
    end
    user_write = 1'b0;
  endtask

  task automatic start_xfer(input logic [31:0] base, input int len);
    ctrl_start = 1'b1;
    ctrl_baseaddress = base;
    ctrl_length = 16'(len);
    exp_addr = base;
    exp_rem = len;
    xfer_len = len;
    beats_total = 0;
    done_cnt = 0;
    busy_cycles = 0;
    start_cyc = cyc;
    step();
    ctrl_start = 1'b0;
  endtask

  task automatic run_to_done(input int max_cyc);
    int n;
    n = 0;
    while (done_cnt == 0 && n < max_cyc) begin
      step();
      n++;
    end
    chk("done_seen", 64'(done_cnt), 64'(1));
    chk("beats_total", 64'(beats_total), 64'(xfer_len));
    step();
    chk("done_once", 64'(done_cnt), 64'(1));
    chk("idle_busy", 64'(ctrl_busy), 64'(0));
  endtask

  initial begin
    int n;
    reset = 1'b1;
    ctrl_start = 1'b0;
    ctrl_baseaddress = '0;
    ctrl_length = '0;
    user_write = 1'b0;
    user_writedata = '0;
    master_waitrequest = 1'b0;
    push_mode = 0;
    wait_mode = 0;
    in_burst = 1'b0;
    stalled = 1'b0;
    beat_idx = 0;
    cyc = 0;
    done_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_write", 64'(master_write), 64'(0));
    chk("rst_address", 64'(master_address), 64'(0));
    chk("rst_burstcount", 64'(master_burstcount), 64'(0));
    chk("rst_writedata", 64'(master_writedata), 64'(0));
    chk("rst_busy", 64'(ctrl_busy), 64'(0));
    chk("rst_done", 64'(ctrl_done), 64'(0));
    chk("rst_full", 64'(user_full), 64'(0));
    chk("byteenable", 64'(master_byteenable), 64'(4'hF));
    reset = 1'b0;

    // Single burst of 8, data 1..8
    push_seq(8, 1'b0);
    start_xfer(32'h1000, 8);
    run_to_done(100);
    chk("latency_8", 64'(done_cyc - start_cyc), 64'(exp_latency(8)));

    // 20 words -> 8, 8, 4
    push_seq(20, 1'b1);
    start_xfer(32'h1000, 20);
    run_to_done(200);
    chk("latency_20", 64'(done_cyc - start_cyc), 64'(exp_latency(20)));

    // Stalls on beats 2 and 5
    push_seq(8, 1'b1);
    wait_mode = 1;
    start_xfer(32'h4000, 8);
    run_to_done(100);
    wait_mode = 0;

    // Slow producer: one word every 3 cycles after start
    push_mode = 2;
    start_xfer(32'h5000, 8);
    run_to_done(200);
    push_mode = 0;
    user_write = 1'b0;

    // Zero-length transfer
    start_xfer(32'h6000, 0);
    run_to_done(20);
    chk("len0_busy_cycles", 64'(busy_cycles), 64'(1));

    // Empty via reset, then overfill with 33 pushes
    reset = 1'b1;
    step();
    reset = 1'b0;
    push_seq(33, 1'b1);
    chk("full_after_33", 64'(user_full), 64'(1));
    push_mode = 1;
    wait_mode = 2;
    start_xfer(32'h2000, 32);
    run_to_done(500);

    // Randomized transfers, including address wrap
    start_xfer(32'hFFFF_FFF0, 20);
    run_to_done(1000);
    for (int t = 0; t < 6; t++) begin
      start_xfer({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, int'($urandom_range(1, 40)));
      run_to_done(2000);
    end
    push_mode = 0;
    wait_mode = 0;
    user_write = 1'b0;

    // Reset during beat 3 of a burst, then a clean transfer
    reset = 1'b1;
    step();
    reset = 1'b0;
    push_seq(8, 1'b1);
    start_xfer(32'h7000, 8);
    n = 0;
    while (!(master_write && in_burst && beat_idx == 2) && n < 50) begin
      step();
      n++;
    end
    chk("reached_beat3", 64'(master_write), 64'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_write", 64'(master_write), 64'(0));
    chk("abort_busy", 64'(ctrl_busy), 64'(0));
    chk("abort_full", 64'(user_full), 64'(0));
    chk("abort_fifo_empty", 64'(master_writedata), 64'(0));
    push_seq(8, 1'b1);
    start_xfer(32'h8000, 8);
    run_to_done(100);
    chk("latency_after_abort", 64'(done_cyc - start_cyc), 64'(exp_latency(8)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
